// File: rtl/usb_pulpino_fifo_channel_pkg.sv
// Shared types and helpers for the buffered USB<->Pulpino GPIO channel.
package usb_pulpino_chan_pkg;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_WAIT = 1'b1
   } tx_state_t;

   // Occupancy counts need one extra bit so that a full FIFO is distinguishable from empty.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/usb_pulpino_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the pointer MSB separates full from empty.
module usb_pulpino_sync_fifo
   import usb_pulpino_chan_pkg::*;
#(
   parameter int pDATA_WIDTH = 8,
   parameter int pDEPTH      = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_push,
   input  logic [pDATA_WIDTH-1:0]        i_data,
   input  logic                          i_pop,
   output logic [pDATA_WIDTH-1:0]        o_data,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [cnt_width(pDEPTH)-1:0]  o_count
);

   localparam int CW = cnt_width(pDEPTH);
   localparam int AW = CW - 1;

   logic [pDATA_WIDTH-1:0] r_mem [pDEPTH];
   logic [CW-1:0]          r_wptr;
   logic [CW-1:0]          r_rptr;
   logic                   w_push_ok;
   logic                   w_pop_ok;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_count   = r_wptr - r_rptr;
   assign o_data    = r_mem[r_rptr[AW-1:0]];
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/usb_pulpino_fifo_channel.sv
// Buffered bidirectional word channel between the host register front-end and Pulpino GPIO.
// Optional handshake statistics outputs are enabled with USB_PULPINO_CHAN_STATS_EN.
module usb_pulpino_fifo_channel
   import usb_pulpino_chan_pkg::*;
#(
   parameter int pDATA_WIDTH = 8,
   parameter int pDEPTH      = 16,
   parameter int pCNT_WIDTH  = cnt_width(pDEPTH)
) (
   input  logic                   clk,
   input  logic                   reset_i,
   input  logic                   enable_i,
   input  logic                   host_wr_en,
   input  logic [pDATA_WIDTH-1:0] host_wr_data,
   input  logic                   host_rd_en,
   output logic [pDATA_WIDTH-1:0] host_rd_data,
   output logic                   host_rd_valid,
   input  logic                   host_clr_err,
   output logic [pCNT_WIDTH-1:0]  tx_count,
   output logic [pCNT_WIDTH-1:0]  rx_count,
   output logic                   tx_overflow,
   output logic                   rx_underflow,
   output logic [pDATA_WIDTH-1:0] gpio_data_in,
   output logic                   data_in_io_turn,
   input  logic                   data_in_pulpino_turn,
   input  logic [pDATA_WIDTH-1:0] gpio_data_out,
   input  logic                   data_out_pulpino_turn,
   output logic                   data_out_io_turn
`ifdef USB_PULPINO_CHAN_STATS_EN
   ,
   output logic [31:0]            tx_words_o,
   output logic [31:0]            rx_words_o
`endif
);

   tx_state_t              r_tx_state;
   tx_state_t              w_tx_next;
   logic                   w_tx_launch;
   logic                   w_tx_done;
   logic [pDATA_WIDTH-1:0] w_tx_head;
   logic                   w_tx_full;
   logic                   w_tx_empty;
   logic                   w_rx_full;
   logic                   w_rx_empty;
   logic                   w_rx_ack;
   logic                   w_tx_ovf_evt;
   logic                   w_rx_unf_evt;
   logic [pDATA_WIDTH-1:0] r_gpio_data_in;
   logic                   r_in_io_turn;
   logic                   r_out_io_turn;
   logic                   r_tx_overflow;
   logic                   r_rx_underflow;

   usb_pulpino_sync_fifo #(
      .pDATA_WIDTH (pDATA_WIDTH),
      .pDEPTH      (pDEPTH)
   ) u_tx_fifo (
      .i_clk   (clk),
      .i_rst   (reset_i),
      .i_push  (host_wr_en),
      .i_data  (host_wr_data),
      .i_pop   (w_tx_launch),
      .o_data  (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (tx_count)
   );

   usb_pulpino_sync_fifo #(
      .pDATA_WIDTH (pDATA_WIDTH),
      .pDEPTH      (pDEPTH)
   ) u_rx_fifo (
      .i_clk   (clk),
      .i_rst   (reset_i),
      .i_push  (w_rx_ack),
      .i_data  (gpio_data_out),
      .i_pop   (host_rd_en),
      .o_data  (host_rd_data),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_count (rx_count)
   );

   always_ff @(posedge clk) begin
      if (reset_i) r_tx_state <= TX_IDLE;
      else         r_tx_state <= w_tx_next;
   end

   always_comb begin
      w_tx_next   = r_tx_state;
      w_tx_launch = 1'b0;
      w_tx_done   = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            if (enable_i && !w_tx_empty) begin
               w_tx_launch = 1'b1;
               w_tx_next   = TX_WAIT;
            end
         end
         TX_WAIT: begin
            if (data_in_pulpino_turn == r_in_io_turn) begin
               w_tx_done = 1'b1;
               w_tx_next = TX_IDLE;
            end
         end
         default: w_tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_gpio_data_in <= '0;
         r_in_io_turn   <= 1'b0;
      end else if (w_tx_launch) begin
         r_gpio_data_in <= w_tx_head;
         r_in_io_turn   <= !r_in_io_turn;
      end
   end

   // A full RX FIFO withholds the echo, so Pulpino keeps its word until space frees up.
   assign w_rx_ack = (data_out_pulpino_turn != r_out_io_turn) && enable_i && !w_rx_full;

   always_ff @(posedge clk) begin
      if (reset_i)       r_out_io_turn <= 1'b0;
      else if (w_rx_ack) r_out_io_turn <= data_out_pulpino_turn;
   end

   assign w_tx_ovf_evt = host_wr_en && w_tx_full;
   assign w_rx_unf_evt = host_rd_en && w_rx_empty;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_tx_overflow  <= 1'b0;
         r_rx_underflow <= 1'b0;
      end else begin
         if (w_tx_ovf_evt)      r_tx_overflow  <= 1'b1;
         else if (host_clr_err) r_tx_overflow  <= 1'b0;
         if (w_rx_unf_evt)      r_rx_underflow <= 1'b1;
         else if (host_clr_err) r_rx_underflow <= 1'b0;
      end
   end

`ifdef USB_PULPINO_CHAN_STATS_EN
   logic [31:0] r_tx_words;
   logic [31:0] r_rx_words;

   always_ff @(posedge clk) begin
      if (reset_i || host_clr_err) begin
         r_tx_words <= '0;
         r_rx_words <= '0;
      end else begin
         if (w_tx_done && r_tx_words != '1) r_tx_words <= r_tx_words + 32'd1;
         if (w_rx_ack && r_rx_words != '1)  r_rx_words <= r_rx_words + 32'd1;
      end
   end

   assign tx_words_o = r_tx_words;
   assign rx_words_o = r_rx_words;
`endif

   assign gpio_data_in     = r_gpio_data_in;
   assign data_in_io_turn  = r_in_io_turn;
   assign data_out_io_turn = r_out_io_turn;
   assign host_rd_valid    = !w_rx_empty;
   assign tx_overflow      = r_tx_overflow;
   assign rx_underflow     = r_rx_underflow;

endmodule

// File: tb/tb_usb_pulpino_fifo_channel.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, randomized traffic vs queue model.
module tb_usb_pulpino_fifo_channel;

   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_i, enable_i, host_wr_en, host_rd_en, host_clr_err;
   logic [DW-1:0] host_wr_data, host_rd_data, gpio_data_in, gpio_data_out;
   logic          host_rd_valid, tx_overflow, rx_underflow;
   logic [4:0]    tx_count, rx_count;
   logic          data_in_io_turn, data_in_pulpino_turn, data_out_pulpino_turn, data_out_io_turn;
`ifdef USB_PULPINO_CHAN_STATS_EN
   logic [31:0]   tx_words_o, rx_words_o;
`endif

   usb_pulpino_fifo_channel #(
      .pDATA_WIDTH (DW),
      .pDEPTH      (DEPTH)
   ) dut (
      .clk                   (clk),
      .reset_i               (reset_i),
      .enable_i              (enable_i),
      .host_wr_en            (host_wr_en),
      .host_wr_data          (host_wr_data),
      .host_rd_en            (host_rd_en),
      .host_rd_data          (host_rd_data),
      .host_rd_valid         (host_rd_valid),
      .host_clr_err          (host_clr_err),
      .tx_count              (tx_count),
      .rx_count              (rx_count),
      .tx_overflow           (tx_overflow),
      .rx_underflow          (rx_underflow),
      .gpio_data_in          (gpio_data_in),
      .data_in_io_turn       (data_in_io_turn),
      .data_in_pulpino_turn  (data_in_pulpino_turn),
      .gpio_data_out         (gpio_data_out),
      .data_out_pulpino_turn (data_out_pulpino_turn),
      .data_out_io_turn      (data_out_io_turn)
`ifdef USB_PULPINO_CHAN_STATS_EN
      ,
      .tx_words_o            (tx_words_o),
      .rx_words_o            (rx_words_o)
`endif
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: word queues plus handshake bookkeeping.
   logic [DW-1:0] mq_tx[$];
   logic [DW-1:0] mq_rx[$];
   logic          m_busy, m_iit, m_iot, m_ovf, m_unf, m_launch;
   logic [DW-1:0] m_gdi;
   logic [31:0]   m_txw, m_rxw;

   task automatic model_update();
      int txn, rxn;
      logic done, ack;
      if (reset_i) begin
         mq_tx.delete(); mq_rx.delete();
         m_busy = 0; m_iit = 0; m_iot = 0; m_ovf = 0; m_unf = 0; m_launch = 0;
         m_gdi = '0; m_txw = 0; m_rxw = 0;
         return;
      end
      txn = mq_tx.size();
      rxn = mq_rx.size();
      m_launch = 0;
      done = 0;
      if (!m_busy && enable_i && txn > 0) begin
         m_gdi = mq_tx.pop_front();
         m_iit = !m_iit;
         m_busy = 1;
         m_launch = 1;
      end else if (m_busy && data_in_pulpino_turn == m_iit) begin
         m_busy = 0;
         done = 1;
      end
      if (host_wr_en && txn < DEPTH) mq_tx.push_back(host_wr_data);
      if (host_wr_en && txn == DEPTH) m_ovf = 1;
      else if (host_clr_err)          m_ovf = 0;
      if (host_rd_en && rxn > 0) void'(mq_rx.pop_front());
      if (host_rd_en && rxn == 0) m_unf = 1;
      else if (host_clr_err)      m_unf = 0;
      ack = (data_out_pulpino_turn != m_iot) && enable_i && rxn < DEPTH;
      if (ack) begin
         mq_rx.push_back(gpio_data_out);
         m_iot = data_out_pulpino_turn;
      end
      if (host_clr_err) begin
         m_txw = 0; m_rxw = 0;
      end else begin
         if (done && m_txw != 32'hFFFF_FFFF) m_txw++;
         if (ack && m_rxw != 32'hFFFF_FFFF)  m_rxw++;
      end
   endtask

   task automatic compare_model();
      chk("tx_count", 32'(tx_count), 32'(mq_tx.size()));
      chk("rx_count", 32'(rx_count), 32'(mq_rx.size()));
      chk("rd_valid", 32'(host_rd_valid), 32'(mq_rx.size() != 0));
      if (mq_rx.size() != 0) chk("rd_data", 32'(host_rd_data), 32'(mq_rx[0]));
      chk("gpio_data_in", 32'(gpio_data_in), 32'(m_gdi));
      chk("in_io_turn", 32'(data_in_io_turn), 32'(m_iit));
      chk("out_io_turn", 32'(data_out_io_turn), 32'(m_iot));
      chk("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
      chk("rx_underflow", 32'(rx_underflow), 32'(m_unf));
`ifdef USB_PULPINO_CHAN_STATS_EN
      chk("tx_words", tx_words_o, m_txw);
      chk("rx_words", rx_words_o, m_rxw);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_model();
   endtask

   task automatic idle_inputs();
      host_wr_en = 0; host_rd_en = 0; host_clr_err = 0; host_wr_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_i = 1; enable_i = 1;
      data_in_pulpino_turn = 0; data_out_pulpino_turn = 0; gpio_data_out = '0;
      step();
      reset_i = 0;
   endtask

   typedef struct {
      logic wr; logic [7:0] wd; logic rd, clr, en, pit, pot; logic [7:0] gdo;
      logic [4:0] txc, rxc; logic [7:0] gdi; logic iit, iot, vld; logic [7:0] rdd; logic ovf, unf;
   } vec_t;

   vec_t vecs[14];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      // wr wd rd clr en pit pot gdo | txc rxc gdi iit iot vld rdd ovf unf
      vecs[0]  = '{1'b1,8'hA5,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 5'd1,5'd0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0};
      vecs[1]  = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 5'd0,5'd0,8'hA5,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0};
      vecs[2]  = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 5'd0,5'd0,8'hA5,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0};
      vecs[3]  = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 5'd0,5'd0,8'hA5,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0};
      vecs[4]  = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b1,1'b0,8'h00, 5'd0,5'd0,8'hA5,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0};
      vecs[5]  = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b1,1'b1,8'h3C, 5'd0,5'd1,8'hA5,1'b1,1'b1,1'b1,8'h3C,1'b0,1'b0};
      vecs[6]  = '{1'b0,8'h00,1'b1,1'b0,1'b1,1'b1,1'b1,8'h3C, 5'd0,5'd0,8'hA5,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0};
      vecs[7]  = '{1'b0,8'h00,1'b1,1'b1,1'b1,1'b1,1'b1,8'h3C, 5'd0,5'd0,8'hA5,1'b1,1'b1,1'b0,8'h00,1'b0,1'b1};
      vecs[8]  = '{1'b0,8'h00,1'b0,1'b1,1'b1,1'b1,1'b1,8'h3C, 5'd0,5'd0,8'hA5,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0};
      vecs[9]  = '{1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0,8'h5A, 5'd0,5'd0,8'hA5,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0};
      vecs[10] = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b1,1'b0,8'h5A, 5'd0,5'd1,8'hA5,1'b1,1'b0,1'b1,8'h5A,1'b0,1'b0};
      vecs[11] = '{1'b0,8'h00,1'b1,1'b0,1'b1,1'b1,1'b0,8'h5A, 5'd0,5'd0,8'hA5,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0};
      vecs[12] = '{1'b1,8'h77,1'b0,1'b0,1'b0,1'b1,1'b0,8'h5A, 5'd1,5'd0,8'hA5,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0};
      vecs[13] = '{1'b0,8'h00,1'b0,1'b0,1'b1,1'b1,1'b0,8'h5A, 5'd0,5'd0,8'h77,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0};

      // Reset state
      do_reset();
      chk("reset_tx_count", 32'(tx_count), 32'd0);
      chk("reset_rx_count", 32'(rx_count), 32'd0);
      chk("reset_gpio_data_in", 32'(gpio_data_in), 32'd0);
      chk("reset_in_turn", 32'(data_in_io_turn), 32'd0);
      chk("reset_out_turn", 32'(data_out_io_turn), 32'd0);
      chk("reset_rd_valid", 32'(host_rd_valid), 32'd0);

      // Directed vector table: TX handshake, RX offer/pop, underflow vs clear, enable gating
      for (int i = 0; i < 14; i++) begin
         host_wr_en = vecs[i].wr; host_wr_data = vecs[i].wd;
         host_rd_en = vecs[i].rd; host_clr_err = vecs[i].clr; enable_i = vecs[i].en;
         data_in_pulpino_turn = vecs[i].pit; data_out_pulpino_turn = vecs[i].pot;
         gpio_data_out = vecs[i].gdo;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_tx_count", i), 32'(tx_count), 32'(vecs[i].txc));
         chk($sformatf("vec%0d_rx_count", i), 32'(rx_count), 32'(vecs[i].rxc));
         chk($sformatf("vec%0d_gpio_data_in", i), 32'(gpio_data_in), 32'(vecs[i].gdi));
         chk($sformatf("vec%0d_in_turn", i), 32'(data_in_io_turn), 32'(vecs[i].iit));
         chk($sformatf("vec%0d_out_turn", i), 32'(data_out_io_turn), 32'(vecs[i].iot));
         chk($sformatf("vec%0d_rd_valid", i), 32'(host_rd_valid), 32'(vecs[i].vld));
         if (vecs[i].vld) chk($sformatf("vec%0d_rd_data", i), 32'(host_rd_data), 32'(vecs[i].rdd));
         chk($sformatf("vec%0d_overflow", i), 32'(tx_overflow), 32'(vecs[i].ovf));
         chk($sformatf("vec%0d_underflow", i), 32'(rx_underflow), 32'(vecs[i].unf));
      end

      // TX burst with Pulpino stalled: first word in flight, 16 queued, 18th push overflows
      do_reset();
      for (int k = 0; k < 18; k++) begin
         host_wr_en = 1; host_wr_data = 8'(k + 1);
         step();
         if (k == 1) begin
            chk("p2_first_word", 32'(gpio_data_in), 32'd1);
            chk("p2_first_turn", 32'(data_in_io_turn), 32'd1);
         end
         if (k == 16) chk("p2_no_ovf_yet", 32'(tx_overflow), 32'd0);
      end
      idle_inputs();
      chk("p2_tx_full_count", 32'(tx_count), 32'd16);
      chk("p2_overflow", 32'(tx_overflow), 32'd1);
      begin
         int nxt = 2;
         for (int c = 0; c < 200 && nxt <= 17; c++) begin
            data_in_pulpino_turn = m_iit;
            step();
            if (m_launch) begin
               chk("p2_order", 32'(gpio_data_in), 32'(nxt));
               nxt++;
            end
         end
         data_in_pulpino_turn = m_iit;
         step(); step(); step();
         chk("p2_delivered", 32'(nxt), 32'd18);
         chk("p2_tx_drained", 32'(tx_count), 32'd0);
      end

      // RX backpressure: 16 words fill the FIFO, the 17th waits for one host pop
      do_reset();
      for (int k = 0; k < 16; k++) begin
         gpio_data_out = 8'(8'h40 + k);
         data_out_pulpino_turn = !data_out_pulpino_turn;
         step();
      end
      chk("p4_rx_full", 32'(rx_count), 32'd16);
      gpio_data_out = 8'h50;
      data_out_pulpino_turn = !data_out_pulpino_turn;
      step(); step(); step();
      chk("p4_withheld", 32'(data_out_io_turn), 32'(!data_out_pulpino_turn));
      chk("p4_head", 32'(host_rd_data), 32'h40);
      host_rd_en = 1;
      step();
      host_rd_en = 0;
      chk("p4_withheld_on_pop", 32'(data_out_io_turn), 32'(!data_out_pulpino_turn));
      step();
      chk("p4_acked", 32'(data_out_io_turn), 32'(data_out_pulpino_turn));
      chk("p4_rx_refull", 32'(rx_count), 32'd16);
      for (int k = 0; k < 16; k++) begin
         chk("p4_order", 32'(host_rd_data), 32'(8'h41 + k));
         host_rd_en = 1;
         step();
      end
      host_rd_en = 0;
      chk("p4_rx_empty", 32'(rx_count), 32'd0);

      // Reset during TX_WAIT with 5 words queued
      do_reset();
      for (int k = 0; k < 6; k++) begin
         host_wr_en = 1; host_wr_data = 8'(8'h60 + k);
         step();
      end
      idle_inputs();
      chk("p6_queued", 32'(tx_count), 32'd5);
      chk("p6_in_flight", 32'(gpio_data_in), 32'h60);
      reset_i = 1;
      step();
      reset_i = 0;
      chk("p6_tx_count", 32'(tx_count), 32'd0);
      chk("p6_rx_count", 32'(rx_count), 32'd0);
      chk("p6_gpio_data_in", 32'(gpio_data_in), 32'd0);
      chk("p6_in_turn", 32'(data_in_io_turn), 32'd0);
      chk("p6_out_turn", 32'(data_out_io_turn), 32'd0);
`ifdef USB_PULPINO_CHAN_STATS_EN
      chk("p6_tx_words", tx_words_o, 32'd0);
`endif

      // Randomized traffic, alternating push-heavy and pop-heavy phases
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         host_wr_en   = ((c % 1000) < 500) ? ($urandom_range(2, 0) != 0) : ($urandom_range(4, 0) == 0);
         host_wr_data = 8'($urandom);
         host_rd_en   = ((c % 1000) < 500) ? ($urandom_range(4, 0) == 0) : ($urandom_range(2, 0) != 0);
         host_clr_err = ($urandom_range(19, 0) == 0);
         enable_i     = ($urandom_range(7, 0) != 0);
         if (m_busy && $urandom_range(2, 0) == 0) data_in_pulpino_turn = m_iit;
         if (data_out_pulpino_turn == m_iot && $urandom_range(2, 0) == 0) begin
            gpio_data_out = 8'($urandom);
            data_out_pulpino_turn = !data_out_pulpino_turn;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
